// File: rtl/lsu_bus_bridge_pkg.sv
// Shared definitions for the load/store bus bridge: funct3 access modes,
// FSM state encoding, byte-enable lane patterns and a legality check.
package lsu_bus_bridge_pkg;
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  // Supported mode with natural alignment for its size.
  function automatic logic mode_ok(input logic [2:0] mode, input logic [1:0] lane);
    case (mode)
      MODE_B, MODE_BU: mode_ok = 1'b1;
      MODE_H, MODE_HU: mode_ok = ~lane[0];
      MODE_W:          mode_ok = (lane == 2'b00);
      default:         mode_ok = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replicated data, plus
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_bus_bridge_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  lane,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        legal
);
  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    legal     = mode_ok(mode, lane);
    rb        = rdata[{lane, 3'b000} +: 8];
    rh        = lane[1] ? rdata[31:16] : rdata[15:0];
    be        = BE_W;
    wdata     = wd;
    rdata_ext = rdata;
    // mode[2] marks the unsigned variants
    case (mode)
      MODE_B, MODE_BU: begin
        be        = BE_B << lane;
        wdata     = {4{wd[7:0]}};
        rdata_ext = {{24{rb[7] & ~mode[2]}}, rb};
      end
      MODE_H, MODE_HU: begin
        be        = BE_H << {lane[1], 1'b0};
        wdata     = {2{wd[15:0]}};
        rdata_ext = {{16{rh[15] & ~mode[2]}}, rh};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu_bus_bridge.sv
// MEM-stage load/store unit: turns byte-addressed accesses into word-aligned
// ready/valid bus transactions and stalls the pipeline until each completes.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        mode_m,
  input  logic [31:0]       addr_m,
  input  logic [31:0]       write_data_m,
  output logic [31:0]       read_data_m,
  output logic              lsu_stall,
  output logic              misaligned,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);
  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  mode_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic [2:0]  mode_sel;
  logic [1:0]  lane_sel;
  logic [3:0]  be;
  logic [31:0] wdata, rdata_ext;
  logic        legal, access, start, timeout;

  assign access   = mem_read_m | mem_write_m;
  // Live MEM-stage fields drive the aligner while idle, latched ones afterwards.
  assign mode_sel = (state == S_IDLE) ? mode_m : mode_q;
  assign lane_sel = (state == S_IDLE) ? addr_m[1:0] : lane_q;

  lsu_align u_align (
    .mode      (mode_sel),
    .lane      (lane_sel),
    .wd        (write_data_m),
    .rdata     (bus_rdata),
    .be        (be),
    .wdata     (wdata),
    .rdata_ext (rdata_ext),
    .legal     (legal)
  );

  assign start       = rst_n && (state == S_IDLE) && access && legal;
  assign misaligned  = rst_n && (state == S_IDLE) && access && !legal;
  assign lsu_stall   = start || (state == S_REQ) || (state == S_WAIT_R);
  assign timeout     = (cnt == 8'(TIMEOUT_CYCLES - 1));
  assign read_data_m = misaligned ? '0 : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      lane_q    <= '0;
      rdata_q   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state     <= S_REQ;
          cnt       <= '0;
          bus_req   <= 1'b1;
          bus_we    <= mem_write_m;
          bus_addr  <= {addr_m[ADDR_W-1:2], 2'b00};
          bus_be    <= be;
          bus_wdata <= wdata;
          mode_q    <= mode_m;
          lane_q    <= addr_m[1:0];
        end
        S_REQ: begin
          cnt <= cnt + 8'd1;
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= bus_we ? S_DONE : S_WAIT_R;
          end else if (timeout) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rdata_q <= '0;
            state   <= S_DONE;
          end
        end
        S_WAIT_R: begin
          cnt <= cnt + 8'd1;
          if (bus_rvalid) begin
            rdata_q <= rdata_ext;
            state   <= S_DONE;
          end else if (timeout) begin
            bus_err <= 1'b1;
            rdata_q <= '0;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
